data_bank_responder: RTL and testbench

DATA_BANK_RESPONDER -- requirements
Module: data_bank_responder

---
 rtl/data_bank_responder.sv | 157 +++++++++++++++
 tb/tb_data_bank_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_bank_responder.sv
// Single memory bank answering one 256 MB address window: zero-clears itself after reset,
// then serves combinational lane-aligned reads and byte-masked stores with exception screening.
package data_bank_responder_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef struct packed {
        logic misaligned;
        logic out_of_range;
    } mem_exception_mask_t;
endpackage

module data_bank_responder
    import data_bank_responder_pkg::*;
#(
    parameter logic [3:0] BANK  = 4'h1,
    parameter int         WORDS = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wr_data,
    input  logic                mem_wr_ena,
    input  mem_access_t         mem_access,
    output logic [31:0]         mem_rd_data,
    output mem_exception_mask_t mem_exception,
    output logic                ready,
    output logic [31:0]         stores_committed,
    output logic [31:0]         stores_rejected
);
    localparam int          AW    = $clog2(WORDS);
    localparam logic [28:0] LIMIT = 29'(WORDS * 4);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_clr_idx, w_clr_idx_nxt;
    logic            w_clr_we;
    logic            r_ready;
    logic [31:0]     r_mem [WORDS];
    logic [31:0]     r_stores_committed, r_stores_rejected;

    logic            w_active, w_in_range, w_misaligned, w_exc_any;
    logic            w_commit, w_reject;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_word, w_rd, w_wdata, w_mask;
    logic [3:0]      w_be;

    // Gating on rst keeps outputs quiet while reset is held, before the clocked reset lands.
    assign w_active     = r_ready && !rst;
    assign w_idx        = mem_addr[2 +: AW];
    assign w_in_range   = (mem_addr[31:28] == BANK) && ({1'b0, mem_addr[27:0]} < LIMIT);

    always_comb begin
        w_misaligned = 1'b0;
        case (mem_access)
            MEM_ACCESS_HALF: w_misaligned = mem_addr[0];
            MEM_ACCESS_WORD: w_misaligned = (mem_addr[1:0] != 2'b00);
            default:         w_misaligned = 1'b0;
        endcase
    end

    assign mem_exception.misaligned   = w_active && w_misaligned;
    assign mem_exception.out_of_range = w_active && !w_in_range;
    assign w_exc_any                  = w_misaligned || !w_in_range;

    assign w_word = r_mem[w_idx];

    always_comb begin
        w_rd = w_word;
        case (mem_access)
            MEM_ACCESS_BYTE: w_rd = {24'h0, w_word[{mem_addr[1:0], 3'b000} +: 8]};
            MEM_ACCESS_HALF: w_rd = {16'h0, w_word[{mem_addr[1], 4'b0000} +: 16]};
            default:         w_rd = w_word;
        endcase
    end

    assign mem_rd_data = (w_active && !w_exc_any) ? w_rd : 32'h0;

    // Store data is replicated across lanes so the byte mask alone selects what lands.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_wr_data;
        case (mem_access)
            MEM_ACCESS_BYTE: begin
                w_be    = 4'b0001 << mem_addr[1:0];
                w_wdata = {4{mem_wr_data[7:0]}};
            end
            MEM_ACCESS_HALF: begin
                w_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_wr_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = mem_wr_data;
            end
        endcase
    end

    assign w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_commit = ena && r_ready && mem_wr_ena && !w_exc_any && !rst;
    assign w_reject = ena && r_ready && mem_wr_ena &&  w_exc_any && !rst;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clr_we      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == AW'(WORDS - 1))
                    w_state_nxt = S_READY;
            end
            default: w_state_nxt = S_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else if (ena) begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_ready   <= (r_state == S_READY);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ena) begin
            if (w_clr_we)
                r_mem[r_clr_idx] <= 32'h0;
            else if (w_commit)
                r_mem[w_idx] <= (w_word & ~w_mask) | (w_wdata & w_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stores_committed <= 32'h0;
            r_stores_rejected  <= 32'h0;
        end else begin
            if (w_commit) r_stores_committed <= r_stores_committed + 32'h1;
            if (w_reject) r_stores_rejected  <= r_stores_rejected + 32'h1;
        end
    end

    assign ready            = r_ready;
    assign stores_committed = r_stores_committed;
    assign stores_rejected  = r_stores_rejected;
endmodule

// File: tb/tb_data_bank_responder.sv
// Randomized bench for data_bank_responder: a little-endian byte-array model predicts reads,
// exceptions and counters; directed tasks cover clear timing, lanes, gating, reset and wrap.
module tb_data_bank_responder;
    import data_bank_responder_pkg::*;

    localparam logic [3:0] BANK  = 4'h1;
    localparam int         WORDS = 16;
    localparam int         NB    = WORDS * 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ena = 1'b1;
    logic [31:0]         mem_addr = 32'h0;
    logic [31:0]         mem_wr_data = 32'h0;
    logic                mem_wr_ena = 1'b0;
    mem_access_t         mem_access = MEM_ACCESS_WORD;
    logic [31:0]         mem_rd_data;
    mem_exception_mask_t mem_exception;
    logic                ready;
    logic [31:0]         stores_committed;
    logic [31:0]         stores_rejected;
    logic [1:0]          exc_bits;

    data_bank_responder #(.BANK(BANK), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
        .mem_access(mem_access), .mem_rd_data(mem_rd_data), .mem_exception(mem_exception),
        .ready(ready), .stores_committed(stores_committed), .stores_rejected(stores_rejected)
    );

    assign exc_bits = mem_exception;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  ref_mem [NB];
    logic [31:0] ref_comm = 0;
    logic [31:0] ref_rej  = 0;

    function automatic int nbytes(mem_access_t acc);
        return (acc == MEM_ACCESS_BYTE) ? 1 : (acc == MEM_ACCESS_HALF) ? 2 : 4;
    endfunction

    // Expected {misaligned, out_of_range}, ignoring readiness.
    function automatic logic [1:0] ref_exc(logic [31:0] a, mem_access_t acc);
        logic oor, mis;
        oor = !((a[31:28] == BANK) && (a[27:0] < 28'(NB)));
        mis = (a % nbytes(acc)) != 0;
        return {mis, oor};
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a, mem_access_t acc);
        logic [31:0] r = 0;
        int b = int'(a[27:0]);
        for (int i = 0; i < nbytes(acc); i++) r = r | (32'(ref_mem[b + i]) << (8 * i));
        return r;
    endfunction

    task automatic ref_store(logic [31:0] a, logic [31:0] d, mem_access_t acc);
        int b = int'(a[27:0]);
        for (int i = 0; i < nbytes(acc); i++) ref_mem[b + i] = d[8 * i +: 8];
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_in(logic [31:0] a, logic [31:0] d, logic we, mem_access_t acc);
        mem_addr = a; mem_wr_data = d; mem_wr_ena = we; mem_access = acc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(32'h1000_0002, 32'h0, 1'b0, MEM_ACCESS_WORD);
        tick(); tick();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (stores_committed !== 32'h0) begin n_err++; $display("FAIL reset_committed: got %h want 0", stores_committed); end
        n_cmp++; if (stores_rejected !== 32'h0) begin n_err++; $display("FAIL reset_rejected: got %h want 0", stores_rejected); end
        n_cmp++; if (exc_bits !== 2'b00) begin n_err++; $display("FAIL reset_exc: got %b want 00", exc_bits); end
        n_cmp++; if (mem_rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %h want 0", mem_rd_data); end
    endtask

    // Counts edges after release until ready; a store is offered mid-clear and must vanish.
    task automatic test_clear();
        int first = 0;
        rst = 1'b0;
        for (int e = 1; e <= 40 && first == 0; e++) begin
            if (e == 6) set_in(32'h1000_0008, 32'hDEAD_BEEF, 1'b1, MEM_ACCESS_WORD);
            if (e == 7) mem_wr_ena = 1'b0;
            tick();
            if (ready) first = e;
        end
        n_cmp++; if (first !== WORDS + 1) begin n_err++; $display("FAIL clear_latency: got edge %0d want %0d", first, WORDS + 1); end
        for (int i = 0; i < NB; i++) ref_mem[i] = 8'h0;
        n_cmp++; if (stores_committed !== 32'h0) begin n_err++; $display("FAIL clear_committed: got %h want 0", stores_committed); end
        n_cmp++; if (stores_rejected !== 32'h0) begin n_err++; $display("FAIL clear_rejected: got %h want 0", stores_rejected); end
        for (int w = 0; w < WORDS; w++) begin
            set_in(32'h1000_0000 + 32'(w * 4), 32'h0, 1'b0, MEM_ACCESS_WORD);
            #1;
            n_cmp++; if (mem_rd_data !== 32'h0) begin n_err++; $display("FAIL clear_word%0d: got %h want 0", w, mem_rd_data); end
        end
    endtask

    task automatic test_lanes();
        set_in(32'h1000_0004, 32'hAABB_CCDD, 1'b1, MEM_ACCESS_WORD); tick();
        set_in(32'h1000_0005, 32'h0000_0011, 1'b1, MEM_ACCESS_BYTE); tick();
        set_in(32'h1000_0006, 32'h0000_2233, 1'b1, MEM_ACCESS_HALF); tick();
        ref_store(32'h1000_0004, 32'hAABB_CCDD, MEM_ACCESS_WORD);
        ref_store(32'h1000_0005, 32'h0000_0011, MEM_ACCESS_BYTE);
        ref_store(32'h1000_0006, 32'h0000_2233, MEM_ACCESS_HALF);
        ref_comm = 3;
        set_in(32'h1000_0004, 32'h0, 1'b0, MEM_ACCESS_WORD); #1;
        n_cmp++; if (mem_rd_data !== 32'h2233_11DD) begin n_err++; $display("FAIL lanes_word: got %h want 223311dd", mem_rd_data); end
        set_in(32'h1000_0007, 32'h0, 1'b0, MEM_ACCESS_BYTE); #1;
        n_cmp++; if (mem_rd_data !== 32'h0000_0022) begin n_err++; $display("FAIL lanes_byte: got %h want 00000022", mem_rd_data); end
        set_in(32'h1000_0006, 32'h0, 1'b0, MEM_ACCESS_HALF); #1;
        n_cmp++; if (mem_rd_data !== 32'h0000_2233) begin n_err++; $display("FAIL lanes_half: got %h want 00002233", mem_rd_data); end
        n_cmp++; if (stores_committed !== 32'd3) begin n_err++; $display("FAIL lanes_committed: got %0d want 3", stores_committed); end
    endtask

    task automatic test_exceptions();
        set_in(32'h1000_0002, 32'hFFFF_FFFF, 1'b1, MEM_ACCESS_WORD); #1;
        n_cmp++; if (exc_bits !== 2'b10) begin n_err++; $display("FAIL exc_misaligned: got %b want 10", exc_bits); end
        n_cmp++; if (mem_rd_data !== 32'h0) begin n_err++; $display("FAIL exc_mis_rd: got %h want 0", mem_rd_data); end
        tick(); ref_rej++;
        set_in(32'h1000_0004, 32'h0, 1'b0, MEM_ACCESS_WORD); #1;
        n_cmp++; if (mem_rd_data !== 32'h2233_11DD) begin n_err++; $display("FAIL exc_unchanged: got %h want 223311dd", mem_rd_data); end
        n_cmp++; if (stores_rejected !== 32'd1) begin n_err++; $display("FAIL exc_rejected: got %0d want 1", stores_rejected); end
        set_in(32'h2000_0000, 32'h0, 1'b0, MEM_ACCESS_WORD); #1;
        n_cmp++; if (exc_bits !== 2'b01) begin n_err++; $display("FAIL exc_oor: got %b want 01", exc_bits); end
        n_cmp++; if (mem_rd_data !== 32'h0) begin n_err++; $display("FAIL exc_oor_rd: got %h want 0", mem_rd_data); end
        set_in(32'h1000_003C, 32'h0, 1'b0, MEM_ACCESS_WORD); #1;
        n_cmp++; if (exc_bits !== 2'b00) begin n_err++; $display("FAIL exc_last_word: got %b want 00", exc_bits); end
        set_in(32'h1000_0040, 32'h0, 1'b0, MEM_ACCESS_BYTE); #1;
        n_cmp++; if (exc_bits !== 2'b01) begin n_err++; $display("FAIL exc_limit: got %b want 01", exc_bits); end
        set_in(32'h1000_0041, 32'h5555, 1'b1, MEM_ACCESS_HALF); #1;
        n_cmp++; if (exc_bits !== 2'b11) begin n_err++; $display("FAIL exc_both: got %b want 11", exc_bits); end
        tick(); ref_rej++; mem_wr_ena = 1'b0;
        n_cmp++; if (stores_rejected !== ref_rej) begin n_err++; $display("FAIL exc_rejected2: got %0d want %0d", stores_rejected, ref_rej); end
        n_cmp++; if (stores_committed !== ref_comm) begin n_err++; $display("FAIL exc_committed: got %0d want %0d", stores_committed, ref_comm); end
    endtask

    task automatic test_gating();
        ena = 1'b0;
        set_in(32'h1000_0010, 32'h1234_5678, 1'b1, MEM_ACCESS_WORD); tick();
        set_in(32'h1000_0011, 32'h1234_5678, 1'b1, MEM_ACCESS_WORD); tick();
        ena = 1'b1;
        set_in(32'h1000_0010, 32'h0, 1'b0, MEM_ACCESS_WORD); #1;
        n_cmp++; if (mem_rd_data !== 32'h0) begin n_err++; $display("FAIL gate_nowrite: got %h want 0", mem_rd_data); end
        n_cmp++; if (stores_committed !== ref_comm) begin n_err++; $display("FAIL gate_committed: got %0d want %0d", stores_committed, ref_comm); end
        n_cmp++; if (stores_rejected !== ref_rej) begin n_err++; $display("FAIL gate_rejected: got %0d want %0d", stores_rejected, ref_rej); end
    endtask

    task automatic test_back_to_back();
        set_in(32'h1000_0014, 32'hCAFE_F00D, 1'b1, MEM_ACCESS_WORD); #1;
        n_cmp++; if (mem_rd_data !== ref_read(32'h1000_0014, MEM_ACCESS_WORD)) begin n_err++; $display("FAIL rw_old: got %h want %h", mem_rd_data, ref_read(32'h1000_0014, MEM_ACCESS_WORD)); end
        tick(); ref_store(32'h1000_0014, 32'hCAFE_F00D, MEM_ACCESS_WORD); ref_comm++;
        mem_wr_ena = 1'b0; #1;
        n_cmp++; if (mem_rd_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rw_new: got %h want cafef00d", mem_rd_data); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp_rd;
        logic [1:0]  e;
        logic        we;
        mem_access_t acc;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0:       a = {4'($urandom_range(2, 15)), 28'($urandom_range(0, NB - 1))};
                1:       a = {BANK, 28'(NB + $urandom_range(0, 15))};
                default: a = {BANK, 28'($urandom_range(0, NB - 1))};
            endcase
            acc = mem_access_t'($urandom_range(0, 2));
            d   = $urandom;
            we  = ($urandom_range(0, 1) == 1);
            set_in(a, d, we, acc); #1;
            e = ref_exc(a, acc);
            exp_rd = (e != 2'b00) ? 32'h0 : ref_read(a, acc);
            n_cmp++; if (exc_bits !== e) begin n_err++; $display("FAIL rnd_exc it%0d a=%h: got %b want %b", it, a, exc_bits, e); end
            n_cmp++; if (mem_rd_data !== exp_rd) begin n_err++; $display("FAIL rnd_rd it%0d a=%h: got %h want %h", it, a, mem_rd_data, exp_rd); end
            tick();
            if (we) begin
                if (e != 2'b00) ref_rej++;
                else begin ref_store(a, d, acc); ref_comm++; end
            end
            n_cmp++; if (stores_committed !== ref_comm) begin n_err++; $display("FAIL rnd_comm it%0d: got %0d want %0d", it, stores_committed, ref_comm); end
            n_cmp++; if (stores_rejected !== ref_rej) begin n_err++; $display("FAIL rnd_rej it%0d: got %0d want %0d", it, stores_rejected, ref_rej); end
        end
        mem_wr_ena = 1'b0;
    endtask

    task automatic test_wrap();
        force dut.r_stores_committed = 32'hFFFF_FFFF;
        #1;
        release dut.r_stores_committed;
        #1;
        n_cmp++; if (stores_committed !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preset: got %h want ffffffff", stores_committed); end
        set_in(32'h1000_0020, 32'h0000_00A5, 1'b1, MEM_ACCESS_BYTE); tick();
        mem_wr_ena = 1'b0;
        n_cmp++; if (stores_committed !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %h want 0", stores_committed); end
    endtask

    task automatic test_mid_reset();
        int first = 0;
        set_in(32'h1000_0014, 32'h0, 1'b0, MEM_ACCESS_WORD);
        rst = 1'b1; #1;
        n_cmp++; if (mem_rd_data !== 32'h0) begin n_err++; $display("FAIL rst_rd_quiet: got %h want 0", mem_rd_data); end
        set_in(32'h1000_0002, 32'h0, 1'b0, MEM_ACCESS_WORD); #1;
        n_cmp++; if (exc_bits !== 2'b00) begin n_err++; $display("FAIL rst_exc_quiet: got %b want 00", exc_bits); end
        tick(); rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int e = 1; e <= 40 && first == 0; e++) begin
            tick();
            if (ready) first = e;
        end
        n_cmp++; if (first !== WORDS + 1) begin n_err++; $display("FAIL midrst_latency: got edge %0d want %0d", first, WORDS + 1); end
        n_cmp++; if (stores_committed !== 32'h0) begin n_err++; $display("FAIL midrst_committed: got %h want 0", stores_committed); end
        n_cmp++; if (stores_rejected !== 32'h0) begin n_err++; $display("FAIL midrst_rejected: got %h want 0", stores_rejected); end
        set_in(32'h1000_0014, 32'h0, 1'b0, MEM_ACCESS_WORD); #1;
        n_cmp++; if (mem_rd_data !== 32'h0) begin n_err++; $display("FAIL midrst_cleared: got %h want 0", mem_rd_data); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_lanes();
        test_exceptions();
        test_gating();
        test_back_to_back();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
